// File: rtl/unit_literal_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : unit_literal_serializer
//  Description : Captures a batch of unit-clause marks and implied values,
//                drops already-assigned variables and slot 0, then streams
//                the surviving implied literals one per cycle in ascending
//                variable order over a valid/ready handshake. Each batch
//                ends with a one-cycle done pulse carrying the literal count.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid / in_ready   - batch handshake
//                mark_in, val_in,
//                assigned_in           - per-variable batch vectors
//                flush                 - synchronous abort of current batch
//                out_valid / out_ready - literal stream handshake
//                out_lit, out_last     - signed literal, final-beat flag
//                done, count           - batch-complete pulse, literal count
//  Revision    : 1.0 - initial release
// ============================================================================
module unit_literal_serializer #(
    parameter int WIDTH    = 9,
    parameter int MAX_SIZE = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_SIZE-1:0] mark_in,
    input  logic [MAX_SIZE-1:0] val_in,
    input  logic [MAX_SIZE-1:0] assigned_in,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_lit,
    output logic                out_last,
    output logic                done,
    output logic [WIDTH-1:0]    count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [MAX_SIZE-1:0] C_PEND_ONE  = MAX_SIZE'(1);
    localparam logic [MAX_SIZE-1:0] C_SLOT_MASK = ~C_PEND_ONE;
    localparam logic [WIDTH-1:0]    C_ONE_W     = WIDTH'(1);

    state_t              r_state;
    logic [MAX_SIZE-1:0] r_pend;
    logic [MAX_SIZE-1:0] r_val;
    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_count;

    logic [MAX_SIZE-1:0] w_capture;
    logic [MAX_SIZE-1:0] w_pend_next;
    logic                w_single;
    logic [WIDTH-2:0]    w_idx;
    logic [WIDTH-1:0]    w_mag;
    logic [WIDTH-1:0]    w_lit;

    // Slot 0 is reserved, so it is masked off at capture time.
    assign w_capture   = mark_in & ~assigned_in & C_SLOT_MASK;

    // x & (x-1) clears the lowest set bit: this is both the post-beat
    // pending vector and the "exactly one bit left" test.
    assign w_pend_next = r_pend & (r_pend - C_PEND_ONE);
    assign w_single    = (r_pend != '0) && (w_pend_next == '0);

    // Priority encoder: scanning downward lets the lowest set bit win.
    always_comb begin
        w_idx = '0;
        for (int i = MAX_SIZE - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_idx = (WIDTH-1)'(i);
            end
        end
    end

    assign w_mag = {1'b0, w_idx};
    assign w_lit = r_val[w_idx] ? w_mag : (~w_mag + C_ONE_W);

    // All outputs are decoded from registered state only.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign out_lit   = out_valid ? w_lit : '0;
    assign out_last  = out_valid && w_single;
    assign done      = (r_state == S_DONE);
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_val   <= '0;
            r_cnt   <= '0;
            r_count <= '0;
        end else if (flush) begin
            // Abort wins over any handshake this cycle; count is untouched.
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pend <= w_capture;
                        r_val  <= val_in;
                        r_cnt  <= '0;
                        if (w_capture != '0) begin
                            r_state <= S_EMIT;
                        end else begin
                            r_state <= S_DONE;
                            r_count <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_pend <= w_pend_next;
                        r_cnt  <= r_cnt + C_ONE_W;
                        if (w_single) begin
                            r_state <= S_DONE;
                            r_count <= r_cnt + C_ONE_W;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unit_literal_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unit_literal_serializer
//  Description : Directed bench for unit_literal_serializer. A queue-based
//                model predicts the literal stream, the done pulse and the
//                held count cycle by cycle; directed checks pin the model
//                against hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_literal_serializer;

    localparam int W = 9;
    localparam int N = 256;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] mark_in;
    logic [N-1:0] val_in;
    logic [N-1:0] assigned_in;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_lit;
    logic         out_last;
    logic         done;
    logic [W-1:0] count;

    unit_literal_serializer #(.WIDTH(W), .MAX_SIZE(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mark_in     (mark_in),
        .val_in      (val_in),
        .assigned_in (assigned_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lit     (out_lit),
        .out_last    (out_last),
        .done        (done),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] model_q[$];   // literals still to be emitted
    logic [W-1:0] obs[$];       // literals the DUT actually transferred
    bit           done_due;     // done must show in the current cycle
    int           model_cnt;    // literals transferred in current batch
    int           model_count;  // expected value of held count output

    function automatic void build_batch(input logic [N-1:0] m, input logic [N-1:0] v,
                                        input logic [N-1:0] a);
        logic [W-1:0] mag;
        model_q.delete();
        for (int i = 1; i < N; i++) begin
            if (m[i] && !a[i]) begin
                mag = W'(i);
                model_q.push_back(v[i] ? mag : W'(-int'(i)));
            end
        end
    endfunction

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_done;
        bit exp_ready;
        if (!rst_n) begin
            model_q.delete();
            done_due    = 1'b0;
            model_cnt   = 0;
            model_count = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            exp_valid = (model_q.size() > 0);
            exp_done  = done_due;
            exp_ready = !exp_valid && !exp_done;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("done", 32'(done), 32'(exp_done));
            if (exp_valid) begin
                check("out_lit", 32'(out_lit), 32'(model_q[0]));
                check("out_last", 32'(out_last), 32'(model_q.size() == 1));
            end
            if (exp_done) model_count = model_cnt;
            check("count", 32'(count), 32'(model_count));
            if (flush) begin
                model_q.delete();
                done_due = 1'b0;
            end else if (exp_done) begin
                done_due = 1'b0;
            end else if (exp_ready && in_valid) begin
                build_batch(mark_in, val_in, assigned_in);
                model_cnt = 0;
                if (model_q.size() == 0) done_due = 1'b1;
            end else if (exp_valid && out_ready) begin
                obs.push_back(out_lit);
                void'(model_q.pop_front());
                model_cnt++;
                if (model_q.size() == 0) done_due = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        check("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [N-1:0] m, input logic [N-1:0] v, input logic [N-1:0] a);
        wait_idle();
        obs.delete();
        mark_in     = m;
        val_in      = v;
        assigned_in = a;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        // Inputs may change freely once captured.
        mark_in     = ~m;
        val_in      = ~v;
        assigned_in = '0;
    endtask

    task automatic wait_done(input int max);
        bit found = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(found), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_lit"}, 32'(out_lit), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    logic [N-1:0] m, v, a;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        mark_in = '0; val_in = '0; assigned_in = '0;
        done_due = 1'b0; model_cnt = 0; model_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic batch: +3, -7, +200.
        m = '0; v = '0; a = '0;
        m[3] = 1'b1; m[7] = 1'b1; m[200] = 1'b1;
        v[3] = 1'b1; v[200] = 1'b1;
        send(m, v, a);
        wait_done(10);
        check("basic_n", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            check("basic_l0", 32'(obs[0]), 32'h003);
            check("basic_l1", 32'(obs[1]), 32'h1F9);
            check("basic_l2", 32'(obs[2]), 32'h0C8);
        end
        check("basic_count", 32'(count), 32'd3);

        // Suppression and slot 0: only -5 survives.
        m = '0; v = '0; a = '0;
        m[0] = 1'b1; m[5] = 1'b1; m[9] = 1'b1;
        v[0] = 1'b1; v[9] = 1'b1; a[9] = 1'b1;
        send(m, v, a);
        wait_done(10);
        check("supp_n", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) check("supp_l0", 32'(obs[0]), 32'h1FB);
        check("supp_count", 32'(count), 32'd1);

        // Empty batch.
        send('0, '1, '0);
        wait_done(3);
        check("empty_n", 32'(obs.size()), 32'd0);
        check("empty_count", 32'(count), 32'd0);

        // Backpressure: +4 held for three stalled cycles, then -6.
        m = '0; v = '0; a = '0;
        m[4] = 1'b1; m[6] = 1'b1; v[4] = 1'b1;
        out_ready = 1'b0;
        send(m, v, a);
        repeat (3) begin
            check("bp_hold", 32'(out_lit), 32'h004);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(10);
        check("bp_n", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            check("bp_l0", 32'(obs[0]), 32'h004);
            check("bp_l1", 32'(obs[1]), 32'h1FA);
        end
        check("bp_count", 32'(count), 32'd2);

        // Flush coincident with the +2 beat handshake.
        m = '0; v = '0; a = '0;
        m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1; v[3:1] = 3'b111;
        send(m, v, a);
        @(posedge clk); #1;
        check("flush_beat", 32'(out_lit), 32'h002);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 32'(in_ready), 32'd1);
        check("flush_novalid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_n", 32'(obs.size()), 32'd1);
        check("flush_count", 32'(count), 32'd2);
        m = '0; v = '0; m[10] = 1'b1; v[10] = 1'b1;
        send(m, v, a);
        wait_done(10);
        check("after_flush_count", 32'(count), 32'd1);
        if (obs.size() == 1) check("after_flush_l0", 32'(obs[0]), 32'h00A);

        // Asynchronous reset in the middle of EMIT.
        m = '0; v = '0; m[20:1] = '1;
        send(m, v, a);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full batch: every slot 1..255, odd variables true.
        m = '1; v = {128{2'b10}};
        send(m, v, '0);
        wait_done(300);
        check("full_n", 32'(obs.size()), 32'd255);
        if (obs.size() == 255) begin
            check("full_first", 32'(obs[0]), 32'h001);
            check("full_second", 32'(obs[1]), 32'h1FE);
            check("full_last", 32'(obs[254]), 32'h0FF);
        end
        check("full_count", 32'(count), 32'd255);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
